// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder FSM states, block geometry and the initial hash value.
package sha1_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_OUT,
        S_LEN
    } state_t;

    localparam int BLOCK_BYTES = 64;
    localparam int LEN_POS     = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;

    typedef struct packed {
        logic       en;
        logic [5:0] addr;
        logic [7:0] data;
    } buf_wr_t;

endpackage

// File: rtl/sha1_block_buf.sv
// 64-byte block buffer, byte 0 in the MSBs; byte write, length write into bytes 56..63, clear.
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  buf_wr_t       wr,
    input  logic          len_en,
    input  logic [63:0]   len,
    output logic [511:0]  data
);

    logic [511:0] mem;

    // Byte a occupies [511-8a -: 8]; 511-8a == {~a, 3'b111} for a 6-bit a.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else begin
            if (wr.en)
                mem[{~wr.addr, 3'b111} -: 8] <= wr.data;
            if (len_en)
                mem[63:0] <= len;
        end
    end

    assign data = mem;

endmodule

// File: rtl/sha1_padder.sv
// Byte-stream to 512-bit block packer with SHA-1 padding and first/last block flags.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 61
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [511:0]  blk_data,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic          blk_first,
    output logic          blk_last
);

    state_t           state;
    logic [6:0]       ptr;
    logic [LEN_W-1:0] cnt;
    logic             first_pend;
    logic             len_pend;
    logic             end64;
    logic             accept;
    logic             xfer;
    logic             clr;
    logic             len_en;
    buf_wr_t          wr;
    logic [63:0]      bit_len;

    assign accept  = in_valid && in_ready;
    assign xfer    = blk_valid && blk_ready;
    assign bit_len = 64'({cnt, 3'b000});

    always_comb begin
        wr     = '0;
        len_en = 1'b0;
        clr    = 1'b0;
        case (state)
            S_FILL: if (accept) wr = '{en: 1'b1, addr: ptr[5:0], data: in_data};
            S_PAD: begin
                if (ptr != 7'(BLOCK_BYTES)) begin
                    wr     = '{en: 1'b1, addr: ptr[5:0], data: PAD_BYTE};
                    len_en = (ptr < 7'(LEN_POS));
                end
            end
            S_OUT:   clr    = xfer;
            S_LEN:   len_en = 1'b1;
            default: ;
        endcase
    end

    sha1_block_buf u_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .wr     (wr),
        .len_en (len_en),
        .len    (bit_len),
        .data   (blk_data)
    );

    // in_ready is a register so it stays low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FILL;
            ptr        <= '0;
            cnt        <= '0;
            first_pend <= 1'b1;
            len_pend   <= 1'b0;
            end64      <= 1'b0;
            in_ready   <= 1'b0;
            blk_valid  <= 1'b0;
            blk_last   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        ptr <= ptr + 7'd1;
                        cnt <= cnt + 1'b1;
                        if (in_last) begin
                            state    <= S_PAD;
                            in_ready <= 1'b0;
                        end else if (ptr == 7'(BLOCK_BYTES - 1)) begin
                            state     <= S_OUT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    state     <= S_OUT;
                    blk_valid <= 1'b1;
                    if (ptr == 7'(BLOCK_BYTES)) begin
                        blk_last <= 1'b0;
                        end64    <= 1'b1;
                    end else if (ptr < 7'(LEN_POS)) begin
                        blk_last <= 1'b1;
                    end else begin
                        blk_last <= 1'b0;
                        len_pend <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (xfer) begin
                        blk_valid  <= 1'b0;
                        ptr        <= '0;
                        first_pend <= 1'b0;
                        if (blk_last) begin
                            state      <= S_FILL;
                            in_ready   <= 1'b1;
                            cnt        <= '0;
                            first_pend <= 1'b1;
                        end else if (end64) begin
                            state <= S_PAD;
                            end64 <= 1'b0;
                        end else if (len_pend) begin
                            state <= S_LEN;
                        end else begin
                            state    <= S_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    len_pend  <= 1'b0;
                    state     <= S_OUT;
                    blk_valid <= 1'b1;
                    blk_last  <= 1'b1;
                end
                default: state <= S_FILL;
            endcase
        end
    end

    assign blk_first = blk_valid && first_pend;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: padding boundaries, flags, back-pressure and mid-message reset.
module tb_sha1_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         blk_first;
    logic         blk_last;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    sha1_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (blk_valid && blk_ready) xfers++;

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_data = d; in_valid = 1'b1; in_last = last;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_block(output logic [511:0] d, output logic f, output logic l);
        int n = 0;
        blk_ready = 1'b1;
        while (!blk_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL get_block_timeout blk_valid=%b expected 1", blk_valid);
        end
        d = blk_data; f = blk_first; l = blk_last;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    function automatic logic [511:0] abc_block();
        logic [511:0] e = '0;
        e[511:480] = 32'h61626380;
        e[63:0]    = 64'h18;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks += 5;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_valid got %b exp 0", blk_valid); end
        if (blk_data !== '0) begin errors++; $display("FAIL rst_blk_data got %h exp 0", blk_data); end
        if (blk_first !== 1'b0) begin errors++; $display("FAIL rst_blk_first got %b exp 0", blk_first); end
        if (blk_last !== 1'b0) begin errors++; $display("FAIL rst_blk_last got %b exp 0", blk_last); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_abc();
        logic [511:0] d; logic f, l;
        send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
        checks += 2;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL abc_pad_cycle valid got %b exp 0", blk_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abc_pad_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (blk_valid !== 1'b1) begin errors++; $display("FAIL abc_latency valid got %b exp 1", blk_valid); end
        get_block(d, f, l);
        checks += 4;
        if (d !== abc_block()) begin errors++; $display("FAIL abc_data got %h exp %h", d, abc_block()); end
        if (f !== 1'b1) begin errors++; $display("FAIL abc_first got %b exp 1", f); end
        if (l !== 1'b1) begin errors++; $display("FAIL abc_last got %b exp 1", l); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abc_back_to_back in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_55_zeros();
        logic [511:0] d, e; logic f, l;
        for (int i = 0; i < 55; i++) send(8'h00, i == 54);
        get_block(d, f, l);
        e = '0; e[511-8*55 -: 8] = 8'h80; e[63:0] = 64'h1B8;
        checks += 3;
        if (d !== e) begin errors++; $display("FAIL z55_data got %h exp %h", d, e); end
        if (f !== 1'b1) begin errors++; $display("FAIL z55_first got %b exp 1", f); end
        if (l !== 1'b1) begin errors++; $display("FAIL z55_last got %b exp 1", l); end
    endtask

    task automatic test_56_bytes();
        logic [511:0] d, e; logic f, l;
        for (int i = 0; i < 56; i++) send(8'h41, i == 55);
        get_block(d, f, l);
        e = '0;
        for (int i = 0; i < 56; i++) e[511-8*i -: 8] = 8'h41;
        e[511-8*56 -: 8] = 8'h80;
        checks += 3;
        if (d !== e) begin errors++; $display("FAIL b56_blk1_data got %h exp %h", d, e); end
        if (f !== 1'b1) begin errors++; $display("FAIL b56_blk1_first got %b exp 1", f); end
        if (l !== 1'b0) begin errors++; $display("FAIL b56_blk1_last got %b exp 0", l); end
        checks += 2;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL b56_len_cycle valid got %b exp 0", blk_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b56_len_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (blk_valid !== 1'b1) begin errors++; $display("FAIL b56_len_latency valid got %b exp 1", blk_valid); end
        get_block(d, f, l);
        e = '0; e[63:0] = 64'h1C0;
        checks += 3;
        if (d !== e) begin errors++; $display("FAIL b56_blk2_data got %h exp %h", d, e); end
        if (f !== 1'b0) begin errors++; $display("FAIL b56_blk2_first got %b exp 0", f); end
        if (l !== 1'b1) begin errors++; $display("FAIL b56_blk2_last got %b exp 1", l); end
    endtask

    task automatic test_64_ff();
        logic [511:0] d, e; logic f, l;
        for (int i = 0; i < 64; i++) send(8'hFF, i == 63);
        get_block(d, f, l);
        e = '1;
        checks += 3;
        if (d !== e) begin errors++; $display("FAIL ff64_blk1_data got %h exp %h", d, e); end
        if (f !== 1'b1) begin errors++; $display("FAIL ff64_blk1_first got %b exp 1", f); end
        if (l !== 1'b0) begin errors++; $display("FAIL ff64_blk1_last got %b exp 0", l); end
        get_block(d, f, l);
        e = '0; e[511:504] = 8'h80; e[63:0] = 64'h200;
        checks += 3;
        if (d !== e) begin errors++; $display("FAIL ff64_blk2_data got %h exp %h", d, e); end
        if (f !== 1'b0) begin errors++; $display("FAIL ff64_blk2_first got %b exp 0", f); end
        if (l !== 1'b1) begin errors++; $display("FAIL ff64_blk2_last got %b exp 1", l); end
    endtask

    task automatic test_hold();
        int n = 0;
        int x0;
        send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
        while (!blk_valid && n < 20) begin @(posedge clk); #1; n++; end
        x0 = xfers;
        in_data = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks += 4;
            if (blk_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, blk_valid); end
            if (blk_data !== abc_block()) begin errors++; $display("FAIL hold_data cyc %0d got %h exp %h", i, blk_data, abc_block()); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready); end
            if (blk_first !== 1'b1 || blk_last !== 1'b1) begin
                errors++; $display("FAIL hold_flags cyc %0d got %b%b exp 11", i, blk_first, blk_last);
            end
        end
        in_valid = 1'b0;
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        checks += 2;
        if (xfers !== x0 + 1) begin errors++; $display("FAIL hold_xfers got %0d exp %0d", xfers, x0 + 1); end
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL hold_after valid got %b exp 0", blk_valid); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d; logic f, l;
        int x0;
        for (int i = 0; i < 30; i++) send(8'h5A, 1'b0);
        reset = 1'b0;
        #3;
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); end
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", blk_valid); end
        if (blk_data !== '0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", blk_data); end
        x0 = xfers;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
        get_block(d, f, l);
        checks += 4;
        if (d !== abc_block()) begin errors++; $display("FAIL mid_rst_data_abc got %h exp %h", d, abc_block()); end
        if (f !== 1'b1) begin errors++; $display("FAIL mid_rst_first got %b exp 1", f); end
        if (l !== 1'b1) begin errors++; $display("FAIL mid_rst_last got %b exp 1", l); end
        if (xfers !== x0 + 1) begin errors++; $display("FAIL mid_rst_xfers got %0d exp %0d", xfers, x0 + 1); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_55_zeros();
        test_56_bytes();
        test_64_ff();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
